// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, opcode/funct constants and muldiv FSM states
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - issue/result handshake bundle of the EX-stage ALU
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_op, funct, shamt, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_ctl_decode.sv
// rtl/alu_ctl_decode.sv - combinational alu_op/funct decode into ALU control and muldiv strobes
module alu_ctl_decode
  import alu_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctl,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_mfhi,
  output logic       is_mflo,
  output logic       illegal
);

  always_comb begin
    ctl     = ALU_NONE;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:   ctl = ALU_ADD;
          FUNCT_SUB:   ctl = ALU_SUB;
          FUNCT_AND:   ctl = ALU_AND;
          FUNCT_OR:    ctl = ALU_OR;
          FUNCT_SLT:   ctl = ALU_SLT;
          FUNCT_NOR:   ctl = ALU_NOR;
          FUNCT_SLL:   ctl = ALU_SLL;
          FUNCT_SRL:   ctl = ALU_SRL;
          FUNCT_SRA:   ctl = ALU_SRA;
          // Without the muldiv block these four behave like any unknown funct
          FUNCT_MFHI:  if (MULDIV_EN) is_mfhi = 1'b1; else illegal = 1'b1;
          FUNCT_MFLO:  if (MULDIV_EN) is_mflo = 1'b1; else illegal = 1'b1;
          FUNCT_MULTU: if (MULDIV_EN) is_mul = 1'b1;  else illegal = 1'b1;
          FUNCT_DIVU:  if (MULDIV_EN) is_div = 1'b1;  else illegal = 1'b1;
          default:     illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with single-cycle ops and iterative MULTU/DIVU into HI/LO
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_exec_unit_if.slave io
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [3:0]       ctl;
  logic             is_mul, is_div, is_mfhi, is_mflo, illegal;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, hi_w, lo_w, opnd;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, ill_q, out_valid_q;
  logic             in_ready, accept;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, nxt_hi, nxt_lo;
  logic             div_ge;

  alu_ctl_decode #(.MULDIV_EN(MULDIV_EN)) u_dec (
    .alu_op  (io.alu_op),
    .funct   (io.funct),
    .ctl     (ctl),
    .is_mul  (is_mul),
    .is_div  (is_div),
    .is_mfhi (is_mfhi),
    .is_mflo (is_mflo),
    .illegal (illegal)
  );

  assign in_ready     = (state == S_IDLE) && (!out_valid_q || io.out_ready);
  assign accept       = io.in_valid && in_ready;
  assign sh           = SH_W'(io.shamt);
  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.zero      = zero_q;
  assign io.overflow  = ovf_q;
  assign io.illegal   = ill_q;
  assign io.busy      = (state == S_MUL) || (state == S_DIV);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    if (is_mfhi) begin
      alu_res = hi;
    end else if (is_mflo) begin
      alu_res = lo;
    end else begin
      case (ctl)
        ALU_ADD: begin
          alu_res = io.a + io.b;
          alu_ovf = (io.a[WIDTH-1] == io.b[WIDTH-1]) && (alu_res[WIDTH-1] != io.a[WIDTH-1]);
        end
        ALU_SUB: begin
          alu_res = io.a - io.b;
          alu_ovf = (io.a[WIDTH-1] != io.b[WIDTH-1]) && (alu_res[WIDTH-1] != io.a[WIDTH-1]);
        end
        ALU_AND: alu_res = io.a & io.b;
        ALU_OR:  alu_res = io.a | io.b;
        ALU_NOR: alu_res = ~(io.a | io.b);
        ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
        ALU_SLL: alu_res = io.b << sh;
        ALU_SRL: alu_res = io.b >> sh;
        ALU_SRA: alu_res = $signed(io.b) >>> sh;
        default: alu_res = '0;
      endcase
    end
  end

  // hi_w/lo_w hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opnd} : '0);
    div_shift = {hi_w, lo_w[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (state == S_DIV) begin
      nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo = {lo_w[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo_w[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      hi_w        <= '0;
      lo_w        <= '0;
      opnd        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && io.out_ready) out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul || (is_div && io.b != '0)) begin
              hi_w  <= '0;
              lo_w  <= is_mul ? io.b : io.a;
              opnd  <= is_mul ? io.a : io.b;
              cnt   <= '0;
              state <= is_mul ? S_MUL : S_DIV;
            end else if (is_div) begin
              hi          <= io.a;
              lo          <= '1;
              result_q    <= '1;
              zero_q      <= 1'b0;
              ovf_q       <= 1'b0;
              ill_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              ovf_q       <= alu_ovf;
              ill_q       <= illegal;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          hi_w <= nxt_hi;
          lo_w <= nxt_lo;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi          <= nxt_hi;
            lo          <= nxt_lo;
            result_q    <= nxt_lo;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
